// File: rtl/cdma_lite_regs.sv
// AXI4-Lite write-only register block for the CDMA source/destination/length registers.
// Optional byte-lane strobes are enabled by defining CDMA_REGS_STRB_EN.
module cdma_lite_regs #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 26
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic              i_wvalid,
    output logic              o_wready,
`ifdef CDMA_REGS_STRB_EN
    input  logic [3:0]        i_wstrb,
`endif
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic              i_engine_busy,
    output logic [31:0]       o_src_addr,
    output logic [31:0]       o_dst_addr,
    output logic [LEN_W-1:0]  o_byte_len,
    output logic              o_dma_start
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [ADDR_W-1:0] ADDR_SRC = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] ADDR_DST = ADDR_W'(8'h20);
    localparam logic [ADDR_W-1:0] ADDR_LEN = ADDR_W'(8'h28);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    state_t             r_state;
    state_t             w_nextState;
    logic [31:0]        r_srcAddr;
    logic [31:0]        r_dstAddr;
    logic [LEN_W-1:0]   r_byteLen;
    logic [1:0]         r_bresp;
    logic               r_dmaStart;

    logic               w_accept;
    logic [3:0]         w_strb;
    logic               w_hitSrc;
    logic               w_hitDst;
    logic               w_hitLen;
    logic               w_lenBlocked;
    logic               w_lenWrite;
    logic [31:0]        w_srcNext;
    logic [31:0]        w_dstNext;
    logic [LEN_W-1:0]   w_lenNext;
    logic               w_launch;

`ifdef CDMA_REGS_STRB_EN
    assign w_strb = i_wstrb;
`else
    assign w_strb = 4'hF;
`endif

    function automatic logic [31:0] mergeWord(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? newVal[i*8 +: 8] : oldVal[i*8 +: 8];
        end
        return res;
    endfunction

    // Length lanes beyond LEN_W simply have no storage bits to update.
    function automatic logic [LEN_W-1:0] mergeLen(input logic [LEN_W-1:0] oldVal,
                                                  input logic [31:0]      newVal,
                                                  input logic [3:0]       strb);
        logic [LEN_W-1:0] res;
        for (int b = 0; b < LEN_W; b++) begin
            res[b] = strb[b/8] ? newVal[b] : oldVal[b];
        end
        return res;
    endfunction

    assign w_accept     = (r_state == IDLE) & i_awvalid & i_wvalid;
    assign w_hitSrc     = (i_awaddr == ADDR_SRC);
    assign w_hitDst     = (i_awaddr == ADDR_DST);
    assign w_hitLen     = (i_awaddr == ADDR_LEN);
    assign w_lenBlocked = w_hitLen & i_engine_busy;
    assign w_lenWrite   = w_accept & w_hitLen & ~i_engine_busy;
    assign w_srcNext    = mergeWord(r_srcAddr, i_wdata, w_strb);
    assign w_dstNext    = mergeWord(r_dstAddr, i_wdata, w_strb);
    assign w_lenNext    = mergeLen(r_byteLen, i_wdata, w_strb);
    assign w_launch     = w_lenWrite & (|w_strb) & (|w_lenNext);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = RESP;
            RESP:    if (i_bready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_awready = w_accept;
        o_wready  = w_accept;
        o_bvalid  = (r_state == RESP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_srcAddr  <= '0;
            r_dstAddr  <= '0;
            r_byteLen  <= '0;
            r_bresp    <= RESP_OKAY;
            r_dmaStart <= 1'b0;
        end else begin
            r_dmaStart <= w_launch;
            if (w_accept) begin
                if (w_hitSrc) r_srcAddr <= w_srcNext;
                if (w_hitDst) r_dstAddr <= w_dstNext;
                if (w_lenWrite) r_byteLen <= w_lenNext;
                r_bresp <= ((w_hitSrc | w_hitDst | w_hitLen) & ~w_lenBlocked) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign o_bresp     = r_bresp;
    assign o_src_addr  = r_srcAddr;
    assign o_dst_addr  = r_dstAddr;
    assign o_byte_len  = r_byteLen;
    assign o_dma_start = r_dmaStart;

endmodule

// File: tb/tb_cdma_lite_regs.sv
// Scoreboard bench for cdma_lite_regs: stimulus pushes expected responses, a monitor checks each one.
module tb_cdma_lite_regs;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] src;
        logic [31:0] dst;
        logic [25:0] len;
        logic        start;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        engine_busy;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [25:0] byte_len;
    logic        dma_start;

    int   checks = 0;
    int   failures = 0;
    int   startCount = 0;
    bit   seen = 0;
    exp_t expQ[$];

    cdma_lite_regs #(.ADDR_W(10), .LEN_W(26)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_awaddr      (awaddr),
        .i_awvalid     (awvalid),
        .o_awready     (awready),
        .i_wdata       (wdata),
        .i_wvalid      (wvalid),
        .o_wready      (wready),
`ifdef CDMA_REGS_STRB_EN
        .i_wstrb       (wstrb),
`endif
        .o_bresp       (bresp),
        .o_bvalid      (bvalid),
        .i_bready      (bready),
        .i_engine_busy (engine_busy),
        .o_src_addr    (src_addr),
        .o_dst_addr    (dst_addr),
        .o_byte_len    (byte_len),
        .o_dma_start   (dma_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [1:0] resp, input logic [31:0] src,
                                   input logic [31:0] dst, input logic [25:0] len, input logic start);
        exp_t e;
        e.resp = resp; e.src = src; e.dst = dst; e.len = len; e.start = start;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input logic busy, input exp_t e, output int waits, output time hsTime);
        awaddr = addr; wdata = data; wstrb = strb; engine_busy = busy;
        awvalid = 1'b1; wvalid = 1'b1;
        expQ.push_back(e);
        waits = 0;
        hsTime = 0;
        while (1) begin
            @(negedge clk);
            if (awready && wready) break;
            waits++;
            if (waits > 20) begin
                checks++; failures++;
                $display("[TB] FAIL handshake timeout: got no ready, expected ready for addr 0x%03h", addr);
                break;
            end
        end
        hsTime = $time;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: checks each response once, in its first valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (dma_start) startCount++;
            if (bvalid && !seen) begin
                seen = 1;
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected response: got bresp %0b, expected none", bresp);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("bresp", 32'(bresp), 32'(e.resp));
                    checkOutput("src_addr", src_addr, e.src);
                    checkOutput("dst_addr", dst_addr, e.dst);
                    checkOutput("byte_len", 32'(byte_len), 32'(e.len));
                    checkOutput("dma_start", 32'(dma_start), 32'(e.start));
                end
            end else if (!bvalid) begin
                seen = 0;
            end
        end
    end

    initial begin
        int w;
        time t0, t1, t2;
        logic [31:0] curSrc;

        rst_n = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; wstrb = 4'hF;
        bready = 1'b1; engine_busy = 1'b0;
        #12;
        checkOutput("reset bvalid", 32'(bvalid), 32'h0);
        checkOutput("reset bresp", 32'(bresp), 32'h0);
        checkOutput("reset src", src_addr, 32'h0);
        checkOutput("reset dst", dst_addr, 32'h0);
        checkOutput("reset len", 32'(byte_len), 32'h0);
        checkOutput("reset start", 32'(dma_start), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] back-to-back writes with bready high");
        applyStimulus(10'h18, 32'h1000_0000, 4'hF, 0, mkExp(2'b00, 32'h1000_0000, 32'h0, 26'h0, 0), w, t0);
        applyStimulus(10'h20, 32'h2000_0000, 4'hF, 0, mkExp(2'b00, 32'h1000_0000, 32'h2000_0000, 26'h0, 0), w, t1);
        applyStimulus(10'h28, 32'h0000_0040, 4'hF, 0, mkExp(2'b00, 32'h1000_0000, 32'h2000_0000, 26'h40, 1), w, t2);
        checkOutput("throughput gap 1", 32'(t1 - t0), 32'd20);
        checkOutput("throughput gap 2", 32'(t2 - t1), 32'd20);
        drain();
        checkOutput("start pulses after launch", 32'(startCount), 32'd1);

        $display("[TB] address without data");
        awaddr = 10'h20; wdata = 32'h2000_0004; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("awready while wvalid low", 32'(awready), 32'h0);
            checkOutput("wready while wvalid low", 32'(wready), 32'h0);
        end
        @(posedge clk); #1;
        applyStimulus(10'h20, 32'h2000_0004, 4'hF, 0, mkExp(2'b00, 32'h1000_0000, 32'h2000_0004, 26'h40, 0), w, t0);
        checkOutput("accept on wvalid rise", 32'(w), 32'd0);
        drain();

        $display("[TB] decode errors");
        applyStimulus(10'h0C, 32'hDEAD_BEEF, 4'hF, 0, mkExp(2'b10, 32'h1000_0000, 32'h2000_0004, 26'h40, 0), w, t0);
        applyStimulus(10'h19, 32'h0000_0001, 4'hF, 0, mkExp(2'b10, 32'h1000_0000, 32'h2000_0004, 26'h40, 0), w, t0);
        drain();

        $display("[TB] writes while engine busy");
        applyStimulus(10'h28, 32'h0000_0080, 4'hF, 1, mkExp(2'b10, 32'h1000_0000, 32'h2000_0004, 26'h40, 0), w, t0);
        applyStimulus(10'h18, 32'h0000_3000, 4'hF, 1, mkExp(2'b00, 32'h0000_3000, 32'h2000_0004, 26'h40, 0), w, t0);
        engine_busy = 1'b0;
        drain();
        checkOutput("no pulse while busy", 32'(startCount), 32'd1);

        $display("[TB] zero length and truncated length");
        applyStimulus(10'h28, 32'h0000_0000, 4'hF, 0, mkExp(2'b00, 32'h0000_3000, 32'h2000_0004, 26'h0, 0), w, t0);
        applyStimulus(10'h28, 32'hFC00_0010, 4'hF, 0, mkExp(2'b00, 32'h0000_3000, 32'h2000_0004, 26'h10, 1), w, t0);
        drain();
        checkOutput("pulse count after length writes", 32'(startCount), 32'd2);
        curSrc = 32'h0000_3000;

`ifdef CDMA_REGS_STRB_EN
        $display("[TB] byte strobes");
        applyStimulus(10'h18, 32'h1122_3344, 4'hF, 0, mkExp(2'b00, 32'h1122_3344, 32'h2000_0004, 26'h10, 0), w, t0);
        applyStimulus(10'h18, 32'hAABB_CCDD, 4'b0101, 0, mkExp(2'b00, 32'h11BB_33DD, 32'h2000_0004, 26'h10, 0), w, t0);
        applyStimulus(10'h28, 32'h0000_0055, 4'b0000, 0, mkExp(2'b00, 32'h11BB_33DD, 32'h2000_0004, 26'h10, 0), w, t0);
        drain();
        checkOutput("no pulse with empty strobe", 32'(startCount), 32'd2);
        curSrc = 32'h11BB_33DD;
`endif

        $display("[TB] response hold and asynchronous reset");
        bready = 1'b0;
        applyStimulus(10'h20, 32'h0000_5000, 4'hF, 0, mkExp(2'b00, curSrc, 32'h0000_5000, 26'h10, 0), w, t0);
        awaddr = 10'h18; wdata = 32'h0000_9999; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bvalid held", 32'(bvalid), 32'h1);
            checkOutput("bresp held", 32'(bresp), 32'h0);
            checkOutput("awready during hold", 32'(awready), 32'h0);
            checkOutput("wready during hold", 32'(wready), 32'h0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset bvalid", 32'(bvalid), 32'h0);
        checkOutput("async reset src", src_addr, 32'h0);
        checkOutput("async reset dst", dst_addr, 32'h0);
        checkOutput("async reset len", 32'(byte_len), 32'h0);
        checkOutput("async reset start", 32'(dma_start), 32'h0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(10'h18, 32'h0000_4000, 4'hF, 0, mkExp(2'b00, 32'h0000_4000, 32'h0, 26'h0, 0), w, t0);
        drain();

        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdma_lite_regs.md
# cdma_lite_regs

AXI4-Lite write-only responder holding the CDMA transfer registers: source address (0x18), destination address (0x20) and byte length (0x28). It sits on the far side of the control-path AXI-Lite write bus and hands a latched source, destination and length to the copy engine. A write to the byte-length register launches the transfer.

## Interface

Parameters:
- ADDR_W, 10, AXI-Lite address width (awaddr).
- LEN_W, 26, implemented byte-length width; upper wdata bits ignored.

Ports:
- clk  input  1  clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- awaddr  input  ADDR_W  write address.
- awvalid  input  1  address valid.
- awready  output  1  address accepted.
- wdata  input  32  write data.
- wvalid  input  1  data valid.
- wready  output  1  data accepted.
- wstrb  input  4  byte-lane strobes (present only with CDMA_REGS_STRB_EN).
- bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  output  1  response valid.
- bready  input  1  response accepted.
- engine_busy  input  1  copy engine is running a transfer.
- src_addr  output  32  latched source address.
- dst_addr  output  32  latched destination address.
- byte_len  output  LEN_W  latched byte length.
- dma_start  output  1  one-cycle launch pulse to the engine.

## Operation

- States: IDLE (accepting), RESP (bvalid high, waiting for bready).
- awready = wready = (state==IDLE) & awvalid & wvalid, combinational. Address and data are always accepted together in the same cycle. A lone awvalid or lone wvalid is never accepted and waits.
- Handshake cycle (IDLE, both valid): decode, update the register, latch bresp, go to RESP.
- RESP: bvalid=1. If bready, go to IDLE the following edge. Ready stays 0 throughout RESP.
- Address decode uses awaddr[ADDR_W-1:0]:
  - 0x18 writes src_addr. Response OKAY.
  - 0x20 writes dst_addr. Response OKAY.
  - 0x28 writes byte_len = wdata[LEN_W-1:0]. Response OKAY.
  - Any other address, including awaddr[1:0]!=0: response SLVERR, no register changes.
- Writes to 0x18 or 0x20 while engine_busy=1 are OKAY and update the registers. The engine has already latched its copy.
- Write to 0x28 while engine_busy=1: SLVERR, byte_len unchanged, no pulse.
- Write to 0x28 with engine_busy=0:
  - If the written length is nonzero, dma_start pulses.
  - If the written length is 0, byte_len becomes 0, response OKAY, no pulse.
- Reset (asynchronous, any state): state=IDLE, bvalid=0, bresp=2'b00, src_addr=dst_addr=0, byte_len=0, dma_start=0. A response in flight is dropped.

## Timing

- awready/wready rise in the same cycle both valids are high in IDLE (zero-latency accept).
- Handshake at edge N → bvalid=1 and register value visible from N+1. dma_start is high for exactly cycle N+1.
- bready=1 at edge M while in RESP → bvalid=0 and back in IDLE from M+1. A new write can then be accepted in cycle M+1.
- Peak throughput with bready tied high: one write per 2 cycles.
- bresp is stable for the whole time bvalid is high.
- engine_busy is sampled in the handshake cycle only.

## Configuration

- CDMA_REGS_STRB_EN defined:
  - The wstrb port exists.
  - For each byte lane i, the register byte is updated only if wstrb[i]=1. For byte_len, only lanes within LEN_W apply.
  - For 0x28, dma_start fires only if at least one strobe is set and the resulting byte_len is nonzero.
- Not defined:
  - No wstrb port.
  - Every accepted write is a full 32-bit write.

## Test plan

- Write 0x18 ← 0x1000_0000, 0x20 ← 0x2000_0000, 0x28 ← 0x0000_0040 with awvalid/wvalid asserted together and bready=1 → three OKAY responses, one ready per 2 cycles, src/dst/len = 0x1000_0000/0x2000_0000/0x40, single dma_start pulse one cycle after the 0x28 handshake.
- awvalid high with wvalid low for 5 cycles, then wvalid rises → no ready during those 5 cycles; accept in the cycle wvalid rises, OKAY.
- Write 0x0C ← 0xDEAD_BEEF, then 0x19 ← 0x1 → both SLVERR, all registers unchanged, no dma_start.
- engine_busy=1, write 0x28 ← 0x80 → SLVERR, byte_len keeps its old value, no pulse. Write 0x18 ← 0x3000 under the same condition → OKAY, src_addr=0x3000.
- bready held low 4 cycles after a write → bvalid and bresp held stable, awready/wready stay 0 even with a new write pending. Assert rst_n=0 mid-hold → bvalid=0 and all outputs at reset values asynchronously.
- (CDMA_REGS_STRB_EN) with src_addr=0x1122_3344, write 0x18 ← 0xAABB_CCDD with wstrb=4'b0101 → src_addr=0x11BB_33DD.
